// File: rtl/halftone_pkg.sv
// Shared level codes, default thresholds and scheduler state encoding for the
// halftone cell scheduler.
package halftone_pkg;

  localparam logic [1:0] LVL_NONE  = 2'b00;
  localparam logic [1:0] LVL_SMALL = 2'b01;
  localparam logic [1:0] LVL_MED   = 2'b10;
  localparam logic [1:0] LVL_LARGE = 2'b11;

  localparam int DEF_THRESH0 = 200;
  localparam int DEF_THRESH1 = 700;
  localparam int DEF_THRESH2 = 1300;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_CLASSIFY = 3'd2,
    ST_WRITE    = 3'd3,
    ST_FINISH   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/dot_level_classifier.sv
// Registered average-to-dot-level classifier (1-cycle latency, loads on en).
// Build option HT_BLANK_LEVEL_EN adds the blank (no dot) outcome below THRESH0.
module dot_level_classifier
  import halftone_pkg::*;
#(
  parameter int PIX_W   = 11,
  parameter int THRESH0 = DEF_THRESH0,
  parameter int THRESH1 = DEF_THRESH1,
  parameter int THRESH2 = DEF_THRESH2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PIX_W-1:0] avg,
  output logic [1:0]       level
);

`ifdef HT_BLANK_LEVEL_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [PIX_W-1:0] T0 = PIX_W'(THRESH0);
  localparam logic [PIX_W-1:0] T1 = PIX_W'(THRESH1);
  localparam logic [PIX_W-1:0] T2 = PIX_W'(THRESH2);

  logic [1:0] level_next;

  // Strict greater-than ladder; the blank test is checked last.
  always_comb begin
    level_next = LVL_SMALL;
    if (avg > T2) begin
      level_next = LVL_LARGE;
    end else if (avg > T1) begin
      level_next = LVL_MED;
    end else if (BLANK_EN && (avg <= T0)) begin
      level_next = LVL_NONE;
    end else begin
      level_next = LVL_SMALL;
    end
  end

  // Level register, loaded only while the scheduler classifies.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= LVL_NONE;
    end else if (en) begin
      level <= level_next;
    end else begin
      level <= level;
    end
  end

endmodule

// File: rtl/halftone_cell_scheduler.sv
// Frame sequencer: fetches each square cell over req/ack, averages it, and
// writes one dot level per cell. Optional build macro: HT_BLANK_LEVEL_EN.
module halftone_cell_scheduler
  import halftone_pkg::*;
#(
  parameter int CELL_LOG2 = 3,
  parameter int CELLS_X   = 40,
  parameter int CELLS_Y   = 30,
  parameter int PIX_W     = 11,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int ADDR_W    = 11,
  parameter int THRESH1   = DEF_THRESH1,
  parameter int THRESH2   = DEF_THRESH2,
  parameter int THRESH0   = DEF_THRESH0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pix_req,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  input  logic              pix_ack,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              dot_we,
  output logic [ADDR_W-1:0] dot_addr,
  output logic [1:0]        dot_level
);

  localparam int CX_W  = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int CY_W  = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;
  localparam int ACC_W = PIX_W + 2 * CELL_LOG2;

  localparam logic [CELL_LOG2-1:0] P_MAX  = '1;
  localparam logic [CX_W-1:0]      CX_MAX = CX_W'(CELLS_X - 1);
  localparam logic [CY_W-1:0]      CY_MAX = CY_W'(CELLS_Y - 1);

  sched_state_t         state;
  logic [CELL_LOG2-1:0] px, py, px_next, py_next;
  logic [CX_W-1:0]      cx, cx_next;
  logic [CY_W-1:0]      cy, cy_next;
  logic [ACC_W-1:0]     acc;
  logic [PIX_W-1:0]     avg;
  logic                 last_pix, last_cell;

  // Dividing by the cell area is a pure bit select of the accumulator.
  assign avg = acc[ACC_W-1 -: PIX_W];

  // Raster successors of the in-cell and cell counters.
  always_comb begin
    px_next   = px + CELL_LOG2'(1);
    py_next   = py;
    cx_next   = cx + CX_W'(1);
    cy_next   = cy;
    last_pix  = (px == P_MAX) && (py == P_MAX);
    last_cell = (cx == CX_MAX) && (cy == CY_MAX);
    if (px == P_MAX) begin
      px_next = '0;
      py_next = py + CELL_LOG2'(1);
    end else begin
      py_next = py;
    end
    if (cx == CX_MAX) begin
      cx_next = '0;
      cy_next = cy + CY_W'(1);
    end else begin
      cy_next = cy;
    end
  end

  // Scheduler FSM with registered handshake, status and write outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pix_req  <= 1'b0;
      pix_x    <= '0;
      pix_y    <= '0;
      dot_we   <= 1'b0;
      dot_addr <= '0;
      acc      <= '0;
      px       <= '0;
      py       <= '0;
      cx       <= '0;
      cy       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FETCH;
            busy    <= 1'b1;
            pix_req <= 1'b1;
            pix_x   <= '0;
            pix_y   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (pix_ack) begin
            acc <= acc + ACC_W'(pix_data);
            px  <= px_next;
            py  <= py_next;
            if (last_pix) begin
              pix_req <= 1'b0;
              state   <= ST_CLASSIFY;
            end else begin
              pix_x <= X_W'({cx, px_next});
              pix_y <= Y_W'({cy, py_next});
            end
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_CLASSIFY: begin
          dot_we <= 1'b1;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          dot_we <= 1'b0;
          acc    <= '0;
          if (last_cell) begin
            cx       <= '0;
            cy       <= '0;
            dot_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end else begin
            cx       <= cx_next;
            cy       <= cy_next;
            dot_addr <= dot_addr + ADDR_W'(1);
            pix_req  <= 1'b1;
            pix_x    <= X_W'({cx_next, {CELL_LOG2{1'b0}}});
            pix_y    <= Y_W'({cy_next, {CELL_LOG2{1'b0}}});
            state    <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dot_level_classifier #(
    .PIX_W   (PIX_W),
    .THRESH0 (THRESH0),
    .THRESH1 (THRESH1),
    .THRESH2 (THRESH2)
  ) u_classifier (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_CLASSIFY),
    .avg   (avg),
    .level (dot_level)
  );

endmodule

// File: tb/tb_halftone_cell_scheduler.sv
// Scoreboard bench for halftone_cell_scheduler on a 2x2 grid of 2x2-pixel cells.
module tb_halftone_cell_scheduler;

  localparam int EDGE = 4;   // pixels per image edge (2 cells * 2 pixels)

  logic        clk = 1'b0;
  logic        reset, start, busy, done, pix_req, pix_ack, dot_we;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [10:0] pix_data, dot_addr;
  logic [1:0]  dot_level;

  int n_checks = 0;
  int n_fail   = 0;
  int img [EDGE][EDGE];
  int exp_px_q[$], exp_py_q[$], exp_wa_q[$], exp_wl_q[$];
  int we_cycles[$];
  int max_wait = 0;
  int cycle = 0;
  int done_cycle = -1;
  int wr_count = 0;
  bit done_flag = 1'b0;

  halftone_cell_scheduler #(
    .CELL_LOG2(1), .CELLS_X(2), .CELLS_Y(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_ack(pix_ack),
    .pix_data(pix_data), .dot_we(dot_we), .dot_addr(dot_addr),
    .dot_level(dot_level)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference classification straight from the threshold rules.
  function automatic int ref_level(int sum);
    int avg = sum / 4;
    if (avg > 1300) return 3;
    if (avg > 700) return 2;
`ifdef HT_BLANK_LEVEL_EN
    if (avg <= 200) return 0;
`endif
    return 1;
  endfunction

  task automatic set_cell(int c, int v0, int v1, int v2, int v3);
    int bx = (c % 2) * 2;
    int by = (c / 2) * 2;
    img[by][bx] = v0; img[by][bx+1] = v1;
    img[by+1][bx] = v2; img[by+1][bx+1] = v3;
  endtask

  task automatic build_expect();
    exp_px_q.delete(); exp_py_q.delete(); exp_wa_q.delete(); exp_wl_q.delete();
    for (int cy = 0; cy < 2; cy++)
      for (int cx = 0; cx < 2; cx++) begin
        int sum = 0;
        for (int py = 0; py < 2; py++)
          for (int px = 0; px < 2; px++) begin
            exp_px_q.push_back(cx * 2 + px);
            exp_py_q.push_back(cy * 2 + py);
            sum += img[cy * 2 + py][cx * 2 + px];
          end
        exp_wa_q.push_back(cy * 2 + cx);
        exp_wl_q.push_back(ref_level(sum));
      end
  endtask

  // Pixel source: acks after a random 0..max_wait cycle delay.
  initial begin
    int wcnt = -1;
    pix_ack = 1'b0;
    pix_data = '0;
    forever begin
      @(negedge clk);
      if (reset || !pix_req) begin
        pix_ack = 1'b0;
        pix_data = 11'($urandom);
        wcnt = -1;
      end else begin
        if (wcnt < 0) wcnt = $urandom_range(max_wait, 0);
        if (wcnt == 0) begin
          pix_ack = 1'b1;
          pix_data = (pix_x < EDGE && pix_y < EDGE) ? 11'(img[pix_y][pix_x]) : 11'd0;
          wcnt = -1;
        end else begin
          pix_ack = 1'b0;
          pix_data = 11'($urandom);
          wcnt--;
        end
      end
    end
  end

  // Monitor: pops expected reads/writes whenever the DUT presents them.
  initial begin
    logic       prev_pend = 1'b0;
    logic [8:0] prev_x = '0;
    logic [7:0] prev_y = '0;
    forever begin
      @(negedge clk);
      #1;
      cycle++;
      if (reset) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend && pix_req) begin
          check("addr_stable_x", pix_x, prev_x);
          check("addr_stable_y", pix_y, prev_y);
        end
        if (pix_req && pix_ack) begin
          check("req_expected", exp_px_q.size() > 0, 1);
          if (exp_px_q.size() > 0) begin
            check("req_x", pix_x, exp_px_q.pop_front());
            check("req_y", pix_y, exp_py_q.pop_front());
          end
        end
        prev_pend = pix_req && !pix_ack;
        prev_x = pix_x;
        prev_y = pix_y;
        if (dot_we) begin
          wr_count++;
          we_cycles.push_back(cycle);
          check("write_expected", exp_wa_q.size() > 0, 1);
          if (exp_wa_q.size() > 0) begin
            check("write_addr", dot_addr, exp_wa_q.pop_front());
            check("write_level", dot_level, exp_wl_q.pop_front());
          end
        end
        if (done) begin
          done_flag = 1'b1;
          done_cycle = cycle;
          check("busy_low_with_done", busy, 0);
        end
      end
    end
  end

  task automatic run_frame(int mw, bit spam);
    max_wait = mw;
    done_flag = 1'b0;
    wr_count = 0;
    we_cycles.delete();
    build_expect();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);
    check("req_after_start", pix_req, 1);
    for (int i = 0; i < 2000 && !done_flag; i++) begin
      @(negedge clk);
      start = spam && !done_flag && ($urandom_range(3, 0) == 0);
    end
    start = 1'b0;
    check("frame_done", done_flag, 1);
    check("writes_left", exp_wa_q.size(), 0);
    check("reads_left", exp_px_q.size(), 0);
    check("write_count", wr_count, 4);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", pix_req, 0);
    check("rst_we", dot_we, 0);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    check("rst_addr", dot_addr, 0);
    check("rst_level", dot_level, 0);

    // Constant frame with zero-wait acks: fixed cell cadence.
    for (int c = 0; c < 4; c++) set_cell(c, 1000, 1000, 1000, 1000);
    run_frame(0, 1'b0);
    if (we_cycles.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("write_spacing", we_cycles[i] - we_cycles[i-1], 6);
      check("done_after_last_write", done_cycle - we_cycles[3], 1);
    end

    // Threshold boundaries.
    set_cell(0, 700, 700, 700, 700);
    set_cell(1, 700, 700, 700, 704);
    set_cell(2, 1300, 1300, 1300, 1300);
    set_cell(3, 1300, 1300, 1300, 1304);
    run_frame(0, 1'b0);
    set_cell(0, 0, 0, 0, 3);
    set_cell(1, 150, 150, 150, 150);
    set_cell(2, 201, 201, 201, 201);
    set_cell(3, 200, 200, 200, 200);
    run_frame(0, 1'b0);

    // Random images, random backpressure, stray start pulses.
    for (int f = 0; f < 6; f++) begin
      for (int y = 0; y < EDGE; y++)
        for (int x = 0; x < EDGE; x++)
          img[y][x] = (f % 2 == 0) ? int'($urandom_range(2047, 0))
                                   : int'($urandom_range(1400, 100));
      run_frame(5, 1'b1);
    end

    // Reset while fetching cell 2 aborts the frame without a write.
    for (int y = 0; y < EDGE; y++)
      for (int x = 0; x < EDGE; x++) img[y][x] = int'($urandom_range(2047, 0));
    build_expect();
    max_wait = 0;
    wr_count = 0;
    done_flag = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && wr_count < 2; i++) @(negedge clk);
    check("reached_cell2", wr_count, 2);
    @(negedge clk);
    @(negedge clk);
    check("req_before_reset", pix_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_req", pix_req, 0);
    check("abort_busy", busy, 0);
    check("abort_we", dot_we, 0);
    check("abort_addr", dot_addr, 0);
    exp_px_q.delete(); exp_py_q.delete(); exp_wa_q.delete(); exp_wl_q.delete();
    repeat (20) @(negedge clk);
    check("no_write_after_abort", wr_count, 2);
    check("no_done_after_abort", done_flag, 0);

    // Fresh start after the abort restarts at cell 0, pixel (0,0).
    for (int y = 0; y < EDGE; y++)
      for (int x = 0; x < EDGE; x++) img[y][x] = int'($urandom_range(2047, 0));
    run_frame(3, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/halftone_cell_scheduler.md
Name: halftone_cell_scheduler

Overview:
Frame-level sequencer for the halftone dot-size datapath. On `start` it walks the source image in square cells of 2^CELL_LOG2 × 2^CELL_LOG2 pixels and fetches every pixel over a req/ack read port. It averages each cell's 11-bit intensity, classifies the average into a dot-size level and writes one level per cell into the dot map that the renderer reads. It sits between the frame-buffer read arbiter and the dot-map BRAM.

Parameters:
- CELL_LOG2, 3, log2 of cell edge in pixels (8×8 cells).
- CELLS_X, 40, cells per row.
- CELLS_Y, 30, cells per column.
- PIX_W, 11, pixel intensity width.
- X_W, 9, pixel x-coordinate width.
- Y_W, 8, pixel y-coordinate width.
- ADDR_W, 11, dot-map address width.
- THRESH1, 700, medium-dot threshold.
- THRESH2, 1300, large-dot threshold.
- THRESH0, 200, blank threshold (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the frame completes.
- pix_req  out  1  pixel read request.
- pix_x  out  X_W  requested pixel column.
- pix_y  out  Y_W  requested pixel row.
- pix_ack  in  1  read accepted; pix_data valid in this cycle.
- pix_data  in  PIX_W  pixel intensity.
- dot_we  out  1  dot-map write strobe (one cycle).
- dot_addr  out  ADDR_W  cell index, row-major: cy*CELLS_X+cx.
- dot_level  out  2  size level written.

Behaviour:
- **Reset values:** busy, done, pix_req and dot_we are 0. pix_x, pix_y, dot_addr, dot_level, the accumulator and all counters are 0. State is IDLE.
- **Reset mid-frame:** reset takes effect next edge, aborts the frame, and suppresses any partial write.
- **States:** IDLE → FETCH → CLASSIFY → WRITE → (FETCH | FINISH) → IDLE.
- **IDLE:**
  - start=1 moves to FETCH.
  - busy rises in the next cycle, and pix_req is high in that same cycle.
  - start while not in IDLE is ignored.
- **FETCH handshake:**
  - pix_req is held high, with pix_x/pix_y stable, until pix_ack is high.
  - pix_ack may be high in the first request cycle (zero wait).
  - On an ack cycle:
    - acc <= acc + pix_data.
    - The in-cell counters (px, py) advance raster order, px fastest.
  - If more pixels remain, pix_req stays high with the next address in the following cycle.
  - After the last ack (px=py=2^CELL_LOG2-1), pix_req drops and the state moves to CLASSIFY.
- **Address generation:** pix_x = (cx<<CELL_LOG2)+px; pix_y = (cy<<CELL_LOG2)+py.
- **Accumulator and average:**
  - Accumulator width is PIX_W+2*CELL_LOG2 (17 bits); it cannot overflow.
  - avg = acc >> (2*CELL_LOG2), truncating.
- **CLASSIFY (one cycle, registered):**
  - avg > THRESH2 → 2'b11.
  - else avg > THRESH1 → 2'b10.
  - else → 2'b01.
  - Comparisons are strict greater-than.
- **WRITE (one cycle):**
  - dot_we=1, with dot_addr = current cell index and dot_level = the registered level.
  - acc clears.
  - cx advances; on cx wrap, cy advances. dot_addr increments after the write.
- **After WRITE:** the last cell (cx=CELLS_X-1, cy=CELLS_Y-1) goes to FINISH, otherwise back to FETCH.
- **FINISH:** done=1 for one cycle, busy drops in the same cycle, then IDLE. Counters and dot_addr return to 0.
- **Minimum latency:** 2^(2*CELL_LOG2)+2 cycles per cell.

Optional Feature:
HT_BLANK_LEVEL_EN.
- Defined: a fourth outcome is added, checked last. If avg ≤ THRESH0 the level is 2'b00 (no dot), even though ≤THRESH1 would otherwise give 01.
- Undefined: the level is never 00, and THRESH0 is unused.
- Ports and timing are identical in both builds.

Decomposition:
- Package halftone_pkg:
  - Level codes LVL_NONE=2'b00, LVL_SMALL=2'b01, LVL_MED=2'b10, LVL_LARGE=2'b11.
  - Default THRESH0/1/2.
  - Scheduler state encoding.
- One sub-module, dot_level_classifier: registered compare from avg to level, 1-cycle latency, holding the macro-controlled blank branch.
- Counters and FSM stay in the top module.

Test Plan:
1. **Constant frame:** CELL_LOG2=1, CELLS_X=2, CELLS_Y=2; pix_data=1000, pix_ack tied 1; start → exactly 4 dot_we pulses at addr 0,1,2,3, all level 10, 6 cycles apart; done pulse 1 cycle after the 4th write; busy low with done.
2. **Pixel order:** same configuration; cell 1 requests (2,0),(3,0),(2,1),(3,1), then cell 2 requests (0,2),(1,2),(0,3),(1,3).
3. **Threshold boundaries:**
   - Cells {700×4} → 01.
   - {700,700,700,704} (avg 701) → 10.
   - {1300×4} → 10.
   - {1300,1300,1300,1304} → 11.
   - {0,0,0,3} (avg 0, truncation) → 01.
4. **Backpressure:** pix_ack delayed randomly 0–5 cycles; pix_x/pix_y never change while pix_req=1 and unacked; written levels match the zero-wait run.
5. **Reset and start handling:**
   - reset during cell 2 FETCH → next cycle pix_req=busy=dot_we=0, and no write for that cell.
   - A new start restarts at addr 0 / pixel (0,0).
   - start pulses while busy change nothing.
6. **Macro:** cell avg 150 → 00 with HT_BLANK_LEVEL_EN, → 01 without; avg 201 → 01 in both builds.
